// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared fetch-stage constants, types and state encoding
package cpu_pkg;

    localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] ROM_BYTES    = 32'h0000_1000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

    typedef logic [31:0] addr_t;
    typedef logic [31:0] instr_t;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        instr_t instr;
        addr_t  pc;
        addr_t  pc_plus4;
        logic   valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_pc_reg.sv
// rtl/fetch_stage_pc_reg.sv - program counter flop with redirect/hold/+4 next-PC mux
module pc_reg #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = cpu_pkg::RESET_VECTOR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect_en,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    input  logic                     advance,
    output logic [ADDRESS_WIDTH-1:0] pc
);

    logic [ADDRESS_WIDTH-1:0] pc_d;
    logic [ADDRESS_WIDTH-1:0] pc_q;

    always_comb begin
        pc_d = pc_q;
        if (redirect_en) begin
            pc_d = redirect_target;
        end else if (advance) begin
            pc_d = pc_q + ADDRESS_WIDTH'(4);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage: PC, ROM window check, IF/ID register, fault FSM
// Optional perf counters enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       DATA_WIDTH    = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = cpu_pkg::RESET_VECTOR,
    parameter logic [ADDRESS_WIDTH-1:0] ROM_BYTES     = cpu_pkg::ROM_BYTES,
    parameter logic [DATA_WIDTH-1:0]    NOP_INSTR     = cpu_pkg::NOP_INSTR
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     redirect,
    input  logic [ADDRESS_WIDTH-1:0] redirect_target,
    output logic [ADDRESS_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]    rom_data,
    output logic [DATA_WIDTH-1:0]    if_instr,
    output logic [ADDRESS_WIDTH-1:0] if_pc,
    output logic [ADDRESS_WIDTH-1:0] if_pc_plus4,
    output logic                     if_valid,
    output logic                     fetch_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]              perf_fetch_cnt,
    output logic [31:0]              perf_stall_cnt
`endif
);

    import cpu_pkg::*;

    localparam logic [0:0] S_RUN   = RUN;
    localparam logic [0:0] S_FAULT = FAULT;

    // Window bounds carry one extra bit so base+size near 2^AW cannot wrap.
    localparam logic [ADDRESS_WIDTH:0] WIN_LO = {1'b0, RESET_VECTOR};
    localparam logic [ADDRESS_WIDTH:0] WIN_HI = {1'b0, RESET_VECTOR} + {1'b0, ROM_BYTES}
                                              - (ADDRESS_WIDTH+1)'(4);

    logic [ADDRESS_WIDTH-1:0] pc;
    logic [ADDRESS_WIDTH:0]   pc_ext;
    logic                     pc_legal;
    logic                     redirect_en;
    logic                     advance;

    logic [0:0]               state_d,  state_q;
    logic [DATA_WIDTH-1:0]    instr_d,  instr_q;
    logic [ADDRESS_WIDTH-1:0] ifpc_d,   ifpc_q;
    logic [ADDRESS_WIDTH-1:0] ifpc4_d,  ifpc4_q;
    logic                     valid_d,  valid_q;

    pc_reg #(
        .ADDRESS_WIDTH (ADDRESS_WIDTH),
        .RESET_VECTOR  (RESET_VECTOR)
    ) u_pc_reg (
        .clk             (clk),
        .rst             (rst),
        .redirect_en     (redirect_en),
        .redirect_target (redirect_target),
        .advance         (advance),
        .pc              (pc)
    );

    assign pc_ext   = {1'b0, pc};
    assign pc_legal = (pc[1:0] == 2'b00) && (pc_ext >= WIN_LO) && (pc_ext <= WIN_HI);

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        ifpc_d      = ifpc_q;
        ifpc4_d     = ifpc4_q;
        valid_d     = valid_q;
        redirect_en = 1'b0;
        advance     = 1'b0;
        if (state_q == S_RUN) begin
            // Redirect beats stall: the stalled decode instruction is younger and gets squashed.
            if (redirect) begin
                redirect_en = 1'b1;
                instr_d     = NOP_INSTR;
                valid_d     = 1'b0;
            end else if (stall) begin
                state_d = state_q;
            end else if (!pc_legal) begin
                state_d = S_FAULT;
                instr_d = NOP_INSTR;
                valid_d = 1'b0;
            end else begin
                advance = 1'b1;
                instr_d = rom_data;
                ifpc_d  = pc;
                ifpc4_d = pc + ADDRESS_WIDTH'(4);
                valid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_RUN;
            instr_q <= NOP_INSTR;
            ifpc_q  <= '0;
            ifpc4_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
            ifpc4_q <= ifpc4_d;
            valid_q <= valid_d;
        end
    end

    assign rom_addr    = pc;
    assign if_instr    = instr_q;
    assign if_pc       = ifpc_q;
    assign if_pc_plus4 = ifpc4_q;
    assign if_valid    = valid_q;
    assign fetch_fault = (state_q == S_FAULT);

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_d, fetch_cnt_q;
    logic [31:0] stall_cnt_d, stall_cnt_q;

    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (advance) begin
            fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
        if ((state_q == S_RUN) && stall && !redirect) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
